// File: rtl/image_contrast_auto_ctrl.sv
// Auto-contrast gain controller: accumulates frame luma, then at each frame start
// divides target*256*count by the luma sum to produce a 9-bit gain code (256 = 1.0).
module image_contrast_auto_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  target_luma,
  input  logic        vs_in,
  input  logic        hs_in,
  input  logic        valid_i,
  input  logic [23:0] img_data_i,
  output logic [8:0]  adjust_val,
  output logic        adjust_valid,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

  localparam logic [21:0] CNT_MAX  = '1;
  localparam logic [5:0]  LAST_BIT = 6'd37;

  state_t      state, state_nxt;

  logic [15:0] y_mac;
  logic [7:0]  y_q;
  logic        y_vld;

  logic        vs_prev;
  logic        vs_rise;
  logic [31:0] sum, sum_add;
  logic [21:0] count, cnt_add;

  logic [31:0] snap_sum;
  logic [21:0] snap_cnt;
  logic [7:0]  snap_tgt;
  logic        snap_en;
  logic        snap_pend;

  logic [37:0] dvd;
  logic [31:0] rem;
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [5:0]  iter;

  logic        unused_hs;
  assign unused_hs = hs_in;

  assign busy = (state != IDLE);

  always_comb begin
    y_mac = 16'd77  * {8'd0, img_data_i[23:16]}
          + 16'd150 * {8'd0, img_data_i[15:8]}
          + 16'd29  * {8'd0, img_data_i[7:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q   <= '0;
      y_vld <= 1'b0;
    end else begin
      y_q   <= y_mac[15:8];
      y_vld <= valid_i & ~vs_in;
    end
  end

  // The pixel still in the luma stage belongs to the closing frame, so it is
  // folded into the snapshot rather than leaking into the next frame.
  always_comb begin
    sum_add = sum;
    cnt_add = count;
    if (y_vld && (count != CNT_MAX)) begin
      sum_add = sum + {24'd0, y_q};
      cnt_add = count + 22'd1;
    end
  end

  assign vs_rise = vs_in & ~vs_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_prev   <= 1'b0;
      sum       <= '0;
      count     <= '0;
      snap_sum  <= '0;
      snap_cnt  <= '0;
      snap_tgt  <= '0;
      snap_en   <= 1'b0;
      snap_pend <= 1'b0;
    end else begin
      vs_prev   <= vs_in;
      snap_pend <= 1'b0;
      if (vs_rise) begin
        sum   <= '0;
        count <= '0;
        if (state == IDLE) begin
          snap_sum  <= sum_add;
          snap_cnt  <= cnt_add;
          snap_tgt  <= target_luma;
          snap_en   <= enable;
          snap_pend <= (cnt_add != '0);
        end
      end else begin
        sum   <= sum_add;
        count <= cnt_add;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (snap_pend) state_nxt = LOAD;
      LOAD:    state_nxt = DIV;
      DIV:     if (iter == LAST_BIT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rem_sh = {rem, dvd[37]};
    rem_ge = (rem_sh >= {1'b0, snap_sum});
  end

  // Restoring division: dvd shifts out dividend bits and shifts in quotient bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd          <= '0;
      rem          <= '0;
      iter         <= '0;
      adjust_val   <= 9'd256;
      adjust_valid <= 1'b0;
    end else begin
      adjust_valid <= 1'b0;
      case (state)
        LOAD: begin
          dvd  <= 38'({snap_tgt, 8'h00}) * 38'(snap_cnt);
          rem  <= '0;
          iter <= '0;
        end
        DIV: begin
          iter <= iter + 6'd1;
          if (rem_ge) begin
            rem <= 32'(rem_sh - {1'b0, snap_sum});
            dvd <= {dvd[36:0], 1'b1};
          end else begin
            rem <= rem_sh[31:0];
            dvd <= {dvd[36:0], 1'b0};
          end
        end
        DONE: begin
          adjust_valid <= 1'b1;
          if (!snap_en)
            adjust_val <= 9'd256;
          else if ((snap_sum == '0) || (dvd > 38'd511))
            adjust_val <= 9'd511;
          else
            adjust_val <= dvd[8:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_image_contrast_auto_ctrl.sv
// Scoreboard bench for image_contrast_auto_ctrl: directed frames push expected
// gain codes and pulse cycles; a monitor pops them on every adjust_valid.
module tb_image_contrast_auto_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  target_luma;
  logic        vs_in;
  logic        hs_in;
  logic        valid_i;
  logic [23:0] img_data_i;
  logic [8:0]  adjust_val;
  logic        adjust_valid;
  logic        busy;

  typedef struct {
    logic [8:0]  val;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  image_contrast_auto_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .target_luma  (target_luma),
    .vs_in        (vs_in),
    .hs_in        (hs_in),
    .valid_i      (valid_i),
    .img_data_i   (img_data_i),
    .adjust_val   (adjust_val),
    .adjust_valid (adjust_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest expectation in value and cycle.
  always @(negedge clk) begin
    if (adjust_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("adjust_val", {23'd0, adjust_val}, {23'd0, e.val});
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  // 64x4 frame; pixels alternate between c0 and c1.
  task automatic send_frame(input logic [23:0] c0, input logic [23:0] c1);
    for (int line = 0; line < 4; line++) begin
      for (int px = 0; px < 64; px++) begin
        @(negedge clk);
        valid_i    = 1'b1;
        img_data_i = px[0] ? c1 : c0;
      end
      @(negedge clk);
      valid_i = 1'b0;
      hs_in   = 1'b1;
      @(negedge clk);
      hs_in   = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  // Frame start; valid white pixels during vs high must be ignored.
  task automatic vs_rise(input logic exp_pulse, input logic [8:0] exp_val,
                         input logic en, input logic [7:0] tgt);
    @(negedge clk);
    enable      = en;
    target_luma = tgt;
    vs_in       = 1'b1;
    valid_i     = 1'b1;
    img_data_i  = 24'hFFFFFF;
    if (exp_pulse) sb.push_back('{val: exp_val, cyc: cyc + 42});
    repeat (3) @(negedge clk);
    vs_in       = 1'b0;
    valid_i     = 1'b0;
    enable      = 1'b1;
    target_luma = 8'd0;
  endtask

  initial begin
    int w;
    reset = 1'b1; enable = 1'b1; target_luma = 8'd0;
    vs_in = 1'b0; hs_in = 1'b0; valid_i = 1'b0; img_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_adjust_val", {23'd0, adjust_val}, 32'd256);
    check("reset_adjust_valid", {31'd0, adjust_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    vs_rise(1'b0, 9'd0, 1'b1, 8'd128);
    send_frame(24'h808080, 24'h808080);
    vs_rise(1'b1, 9'd256, 1'b1, 8'd128);
    send_frame(24'h646464, 24'h646464);
    vs_rise(1'b1, 9'd327, 1'b1, 8'd128);
    send_frame(24'h404040, 24'h404040);
    vs_rise(1'b1, 9'd511, 1'b1, 8'd128);
    send_frame(24'h000000, 24'h000000);
    vs_rise(1'b1, 9'd511, 1'b1, 8'd128);
    repeat (60) @(negedge clk);
    vs_rise(1'b0, 9'd0, 1'b1, 8'd128);
    repeat (60) @(negedge clk);
    check("empty_frame_hold", {23'd0, adjust_val}, 32'd511);

    send_frame(24'hFF0000, 24'hFF0000);
    vs_rise(1'b1, 9'd431, 1'b1, 8'd128);
    send_frame(24'h00C800, 24'h00C800);
    vs_rise(1'b1, 9'd131, 1'b1, 8'd60);
    send_frame(24'h646464, 24'hC8C8C8);
    vs_rise(1'b1, 9'd218, 1'b1, 8'd128);
    send_frame(24'hC8C8C8, 24'hC8C8C8);
    vs_rise(1'b1, 9'd64, 1'b1, 8'd50);
    send_frame(24'h646464, 24'h646464);
    vs_rise(1'b1, 9'd256, 1'b0, 8'd128);

    send_frame(24'h646464, 24'h646464);
    vs_rise(1'b1, 9'd327, 1'b1, 8'd128);
    repeat (6) @(negedge clk);
    vs_rise(1'b0, 9'd0, 1'b1, 8'd200);
    repeat (80) @(negedge clk);
    check("double_vs_hold", {23'd0, adjust_val}, 32'd327);

    send_frame(24'h808080, 24'h808080);
    vs_rise(1'b0, 9'd0, 1'b1, 8'd128);
    repeat (19) @(posedge clk);
    #2;
    check("busy_in_div", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_adjust_val", {23'd0, adjust_val}, 32'd256);
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    check("post_abort_hold", {23'd0, adjust_val}, 32'd256);

    send_frame(24'h646464, 24'h646464);
    vs_rise(1'b1, 9'd327, 1'b1, 8'd128);

    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/image_contrast_auto_ctrl.md
IMAGE_CONTRAST_AUTO_CTRL -- requirements
Module: image_contrast_auto_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all logic rising-edge.
REQ-002 SHALL have ports: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: enable  input  1  1 = computed gain is applied, 0 = unity gain is output.
REQ-004 SHALL have ports: target_luma  input  8  desired frame mean luma, sampled at the frame-start snapshot.
REQ-005 SHALL have ports: vs_in  input  1  vertical sync; a rising edge marks the start of a frame.
REQ-006 SHALL have ports: hs_in  input  1  horizontal sync, carried for timing only and not used for computation.
REQ-007 SHALL have ports: valid_i  input  1  pixel valid.
REQ-008 SHALL have ports: img_data_i  input  24  pixel {R[23:16], G[15:8], B[7:0]}.
REQ-009 SHALL have ports: adjust_val  output  9  gain code for the contrast stage, 0..511 mapping to 0..2, 256 = 1.0.
REQ-010 SHALL have ports: adjust_valid  output  1  one-cycle pulse when adjust_val updates.
REQ-011 SHALL have ports: busy  output  1  high while the divider state machine is not IDLE.

Function
REQ-012 SHALL compute pixel luma Y = (77*R + 150*G + 29*B) >> 8 (8-bit result), registered as one pipeline stage.
REQ-013 SHALL add Y into a 32-bit sum and increment a 22-bit pixel count for each pixel with valid_i=1 and vs_in=0.
  - Pixels with valid_i=1 while vs_in=1 are ignored.
REQ-014 SHALL stop updating both sum and count once count reaches 2^22-1, holding both values.
REQ-015 SHALL detect the vs_in rising edge with a registered previous value. In that cycle it SHALL:
  - snapshot sum, count and target_luma;
  - clear the accumulators, so the next pixel starts the new frame.
REQ-016 SHALL run FSM IDLE -> LOAD -> DIV -> DONE -> IDLE:
  - IDLE leaves on a snapshot with count != 0.
  - LOAD forms dividend = target*256*count (38 bits) and divisor = sum.
  - DIV performs a 38-iteration restoring division, one quotient bit per cycle.
  - DONE lasts one cycle.
REQ-017 SHALL, in DONE, load adjust_val with:
  - 256 if the snapshot enable=0;
  - otherwise 511 if divisor = 0 or quotient > 511;
  - otherwise quotient[8:0].
  adjust_valid SHALL pulse high in the same cycle.
REQ-018 SHALL assert adjust_valid exactly 41 cycles after the edge at which vs_in is first sampled high (edge detect 1 + LOAD 1 + DIV 38 + DONE 1).
REQ-019 SHALL NOT start the FSM and SHALL NOT pulse adjust_valid for a snapshot with count = 0. In that case adjust_val holds its value.
REQ-020 SHALL, on a vs_in rising edge while busy=1:
  - discard that snapshot and let the current division complete unchanged;
  - still clear the accumulators.
REQ-021 SHALL hold adjust_val constant between DONE cycles.
REQ-022 SHALL compute quotient = floor(dividend / divisor) exactly, with no rounding.

Reset
REQ-023 SHALL, while reset=1, set:
  - adjust_val = 256 and adjust_valid = 0;
  - busy = 0 and FSM = IDLE;
  - sum = 0, count = 0 and the vs edge register = 0.
REQ-024 SHALL abort any in-flight division on reset assertion, with no adjust_valid pulse afterward.

Verification
REQ-025 SHALL cover: 64x4 frame of RGB(128,128,128), target 128, enable 1 -> adjust_valid 41 cycles after next vs rise, adjust_val = 256.
REQ-026 SHALL cover: uniform gray 100, target 128 -> adjust_val = 327 (floor 32768/100).
REQ-027 SHALL cover: uniform gray 64, target 128 -> quotient 512 clamped, adjust_val = 511. An all-black frame -> adjust_val = 511.
REQ-028 SHALL cover: gray 100 frame with enable=0 at snapshot -> adjust_val = 256 with adjust_valid pulse. A frame with no valid pixels -> no pulse, adjust_val unchanged.
REQ-029 SHALL cover: second vs rise 10 cycles after the first (busy=1) -> exactly one pulse carrying the first frame's result.
REQ-030 SHALL cover: reset asserted 20 cycles into DIV -> busy = 0, adjust_val = 256 immediately, no pulse afterward.
